placar: RTL
===========

# placar

Score and lives tracker, the stage directly downstream of the game entities. Consumes hit pulses produced by `entities` and the pause switch, and keeps a 4-digit BCD score and a lives count. Drives the otherwise unused `HEX0`–`HEX5` displays and feeds the `perdeu` flag into `tela`, replacing its current constant 0.

## Interface

Parameters:
- `VIDAS_INICIAIS`, default 3: lives after reset; legal range 1–9.
- `PONTOS_POR_ACERTO`, default 1: BCD points added per enemy hit; legal range 1–9.
- `INVENC_CICLOS`, default 50_000_000: invincibility window after a ship hit, in clock cycles.
- `PISCA_CICLOS`, default 25_000_000: half-period of the game-over blink, in clock cycles.

Ports:
- `CLOCK_50`, in, 1: single clock; all state updates on its rising edge.
- `reset`, in, 1: synchronous, active-high.
- `pausa`, in, 1: level; freezes game state while high.
- `acerto_inimigo`, in, 1: ally ball hit an enemy; level, may stay high several cycles.
- `acerto_nave`, in, 1: enemy ball hit the ship; level.
- `perdeu`, out, 1: game over; goes to `tela.perdeu`.
- `vidas`, out, 4: current lives, binary.
- `pontos`, out, 16: score, 4 BCD digits; `[3:0]` is the units digit.
- `HEX0`–`HEX3`, out, 7 each: score digits, units on `HEX0`.
- `HEX4`, out, 7: always blank.
- `HEX5`, out, 7: lives digit.
- All `HEX` outputs are active-low; bit 6 is segment g; digit 0 is `7'b1000000`; blank is `7'b1111111`.

## Operation

- **Edge detection:**
  - Both hit inputs are registered once.
  - An event is input high with the previous sample low.
  - A held level counts as exactly one event.
- **FSM states:** `JOGANDO`, `INVENCIVEL`, `PERDEU`.
- **JOGANDO:**
  - On an `acerto_inimigo` event, `pontos` increases by `PONTOS_POR_ACERTO` as a BCD add with carry across digits.
  - The score saturates at 9999 and never wraps.
  - On an `acerto_nave` event, `vidas` decrements.
  - If the result is 0, go to `PERDEU`.
  - Otherwise load the invincibility timer with `INVENC_CICLOS-1` and go to `INVENCIVEL`.
- **INVENCIVEL:**
  - Scoring continues.
  - `acerto_nave` events are ignored.
  - The timer decrements once per cycle and the FSM returns to `JOGANDO` on the cycle the timer reads 0.
- **PERDEU:**
  - Terminal state; left only by `reset`.
  - All hit events are ignored and `perdeu` is 1.
  - `HEX0`–`HEX3` and `HEX5` toggle between their digits and blank every `PISCA_CICLOS` cycles, starting with digits shown.
- **Pause:**
  - While `pausa` is 1, hit events are discarded (not queued).
  - The FSM and invincibility timer are frozen; the blink timer keeps running.
  - Edge-detect registers keep sampling, so an input held across un-pause does not generate an event.
- **Simultaneous events:** if both event types occur in the same cycle, both apply. The score increments even if the same cycle's ship hit causes `PERDEU`.
- **Display:**
  - 7-segment decode covers 0–9 only; other codes show blank.
  - Leading zeros of the score are displayed.

## Timing

- **Reset values:**
  - State `JOGANDO`, `pontos`=0, `vidas`=`VIDAS_INICIAIS`, `perdeu`=0, timers 0, blink phase "shown".
  - `HEX0`–`HEX3` show 0, `HEX4` blank, `HEX5` shows `VIDAS_INICIAIS`.
- Reset asserted mid-operation, including during `INVENCIVEL` or `PERDEU`, restores all reset values at the next edge.
- **Latency from input to state:**
  - A hit input rising before edge k is sampled at edge k.
  - `pontos`/`vidas`/`perdeu` update at edge k+1.
- **Display latency:** `HEX` outputs are registered and reflect `pontos`/`vidas` one cycle later, at edge k+2.
- **Invincibility window:** exactly `INVENC_CICLOS` unpaused cycles from entering `INVENCIVEL` to being back in `JOGANDO`. A ship-hit edge on the first `JOGANDO` cycle counts.

## Configuration

- **`PLACAR_INVENCIVEL_EN` defined:** behaviour as above.
- **Undefined:**
  - The `INVENCIVEL` state and timer are not built.
  - Every `acerto_nave` event in `JOGANDO` decrements `vidas` directly.
  - `INVENC_CICLOS` is ignored.

## Test plan

Simulate with `INVENC_CICLOS`=8, `PISCA_CICLOS`=4, `VIDAS_INICIAIS`=3, `PONTOS_POR_ACERTO`=1.

1. Reset, then 12 single-cycle `acerto_inimigo` pulses, plus one pulse held high for 10 cycles → `pontos`=16'h0013, `HEX1`=digit 1, `HEX0`=digit 3.
2. Preload to 9998 via 9998 pulses, then 3 more pulses → `pontos`=16'h9999, no wrap.
3. `acerto_nave` pulse, then another pulse 3 cycles later → `vidas`=2 with the macro defined, `vidas`=1 without it. A pulse 9 cycles after the first → `vidas` decrements.
4. Three spaced ship hits → `perdeu`=1, `HEX5`=digit 0. `HEX` outputs alternate digits/blank every 4 cycles. Further hits leave `pontos` unchanged.
5. `pausa`=1 and pulse both hit inputs → no change; deassert `pausa` with `acerto_inimigo` still high → no event counted.
6. Assert `reset` for one cycle while in `PERDEU` → `perdeu`=0, `vidas`=3, `pontos`=0 on the next cycle.

Source files
------------

// File: rtl/placar.sv
// placar -- score and lives tracker for the game.
//
// Counts enemy hits into a 4-digit BCD score that saturates at 9999, counts
// ship hits against a lives budget, and flags game over. It also drives the
// six 7-segment displays: score on HEX0..HEX3, blank on HEX4, lives on HEX5.
// After game over the digits blink.
//
// Optional feature: define PLACAR_INVENCIVEL_EN to build the post-hit
// invincibility window (INVENCIVEL state plus its timer). When it is not
// defined, every ship hit while playing costs a life immediately.
//
// Ports:
//   CLOCK_50        single clock, rising edge
//   reset           synchronous, active high
//   pausa           level; freezes the game and discards hit events
//   acerto_inimigo  level; enemy hit, one event per rising edge
//   acerto_nave     level; ship hit, one event per rising edge
//   perdeu          game over
//   vidas           lives left, binary
//   pontos          score, 4 BCD digits, [3:0] = units
//   HEX0..HEX5      active-low 7-segment outputs, bit 6 = segment g
module placar #(
   parameter int VIDAS_INICIAIS    = 3,
   parameter int PONTOS_POR_ACERTO = 1,
   parameter int INVENC_CICLOS     = 50_000_000,
   parameter int PISCA_CICLOS      = 25_000_000
) (
   input  logic        CLOCK_50,
   input  logic        reset,
   input  logic        pausa,
   input  logic        acerto_inimigo,
   input  logic        acerto_nave,
   output logic        perdeu,
   output logic [3:0]  vidas,
   output logic [15:0] pontos,
   output logic [6:0]  HEX0,
   output logic [6:0]  HEX1,
   output logic [6:0]  HEX2,
   output logic [6:0]  HEX3,
   output logic [6:0]  HEX4,
   output logic [6:0]  HEX5
);

   localparam logic [6:0] APAGADO = 7'b1111111;
   localparam int PW = (PISCA_CICLOS > 1) ? $clog2(PISCA_CICLOS) : 1;

`ifdef PLACAR_INVENCIVEL_EN
   localparam int TW = (INVENC_CICLOS > 1) ? $clog2(INVENC_CICLOS) : 1;
   typedef enum logic [1:0] {JOGANDO = 2'd0, INVENCIVEL = 2'd1, PERDEU = 2'd2} estado_t;
`else
   typedef enum logic [1:0] {JOGANDO = 2'd0, PERDEU = 2'd2} estado_t;
`endif

   // Active-low segment decode. Codes above 9 show blank.
   function automatic logic [6:0] seg7(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'b1000000;
         4'd1:    s = 7'b1111001;
         4'd2:    s = 7'b0100100;
         4'd3:    s = 7'b0110000;
         4'd4:    s = 7'b0011001;
         4'd5:    s = 7'b0010010;
         4'd6:    s = 7'b0000010;
         4'd7:    s = 7'b1111000;
         4'd8:    s = 7'b0000000;
         4'd9:    s = 7'b0010000;
         default: s = APAGADO;
      endcase
      return s;
   endfunction

   // BCD add of PONTOS_POR_ACERTO with ripple carry. A carry out of the
   // thousands digit means the true sum passed 9999, so clamp instead of wrap.
   function automatic logic [15:0] soma_bcd(input logic [15:0] p);
      logic [15:0] r;
      logic [4:0]  d;
      logic        c;
      r = '0;
      c = 1'b0;
      for (int i = 0; i < 4; i++) begin
         d = {1'b0, p[4*i +: 4]} + {4'd0, c};
         if (i == 0) d = d + 5'(PONTOS_POR_ACERTO);
         if (d > 5'd9) begin
            d = d - 5'd10;
            c = 1'b1;
         end else begin
            c = 1'b0;
         end
         r[4*i +: 4] = d[3:0];
      end
      if (c) r = 16'h9999;
      return r;
   endfunction

   // ---------------- hit edge detection ----------------
   // Sampling never stops, even under pause, so a level held across
   // un-pause has no rising edge left to report.
   logic ini_q, ini_p, nave_q, nave_p;
   logic ev_ini, ev_nave;

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         ini_q  <= 1'b0;
         ini_p  <= 1'b0;
         nave_q <= 1'b0;
         nave_p <= 1'b0;
      end else begin
         ini_q  <= acerto_inimigo;
         ini_p  <= ini_q;
         nave_q <= acerto_nave;
         nave_p <= nave_q;
      end
   end

   assign ev_ini  = ini_q  & ~ini_p  & ~pausa;
   assign ev_nave = nave_q & ~nave_p & ~pausa;

   // ---------------- game FSM ----------------
   estado_t     estado, estado_n;
   logic [15:0] pontos_n;
   logic [3:0]  vidas_n;
`ifdef PLACAR_INVENCIVEL_EN
   logic [TW-1:0] timer, timer_n;
`endif

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         estado <= JOGANDO;
         pontos <= 16'h0000;
         vidas  <= 4'(VIDAS_INICIAIS);
`ifdef PLACAR_INVENCIVEL_EN
         timer  <= '0;
`endif
      end else begin
         estado <= estado_n;
         pontos <= pontos_n;
         vidas  <= vidas_n;
`ifdef PLACAR_INVENCIVEL_EN
         timer  <= timer_n;
`endif
      end
   end

   always_comb begin
      estado_n = estado;
      pontos_n = pontos;
      vidas_n  = vidas;
`ifdef PLACAR_INVENCIVEL_EN
      timer_n  = timer;
`endif
      case (estado)
         JOGANDO: begin
            if (ev_ini) pontos_n = soma_bcd(pontos);
            if (ev_nave) begin
               vidas_n = vidas - 4'd1;
               // Score still lands on the cycle that ends the game.
               if (vidas == 4'd1) begin
                  estado_n = PERDEU;
               end
`ifdef PLACAR_INVENCIVEL_EN
               else begin
                  // Timer counts N-1..0, so the window lasts N cycles.
                  timer_n  = TW'(INVENC_CICLOS - 1);
                  estado_n = INVENCIVEL;
               end
`endif
            end
         end
`ifdef PLACAR_INVENCIVEL_EN
         INVENCIVEL: begin
            if (ev_ini) pontos_n = soma_bcd(pontos);
            if (!pausa) begin
               if (timer == '0) estado_n = JOGANDO;
               else             timer_n  = timer - TW'(1);
            end
         end
`endif
         default: ;  // PERDEU: terminal until reset
      endcase
   end

   assign perdeu = (estado == PERDEU);

   // ---------------- blink and display ----------------
   // The blink timer ignores pausa; it only runs in PERDEU, where it starts
   // from zero with the digits shown.
   logic [PW-1:0]       pisca_cnt;
   logic                apagado;
   logic [3:0][6:0]     dig_q;
   logic [6:0]          vid_q;

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         pisca_cnt <= '0;
         apagado   <= 1'b0;
         for (int i = 0; i < 4; i++) dig_q[i] <= seg7(4'd0);
         vid_q     <= seg7(4'(VIDAS_INICIAIS));
      end else begin
         if (estado == PERDEU) begin
            if (pisca_cnt == PW'(PISCA_CICLOS - 1)) begin
               pisca_cnt <= '0;
               apagado   <= ~apagado;
            end else begin
               pisca_cnt <= pisca_cnt + PW'(1);
            end
         end
         for (int i = 0; i < 4; i++)
            dig_q[i] <= apagado ? APAGADO : seg7(pontos[4*i +: 4]);
         vid_q <= apagado ? APAGADO : seg7(vidas);
      end
   end

   assign HEX0 = dig_q[0];
   assign HEX1 = dig_q[1];
   assign HEX2 = dig_q[2];
   assign HEX3 = dig_q[3];
   assign HEX4 = APAGADO;
   assign HEX5 = vid_q;

endmodule
